// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if: pattern/mode inputs and LED drive output of the LED fader stage.
interface led_fade_pwm_if;
  logic [3:0] led_in;
  logic       fade_en;
  logic [3:0] led_out;
  modport master (output led_in, fade_en, input led_out);
  modport slave (input led_in, fade_en, output led_out);
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: comet-trail LED fader; each LED jumps to full brightness while lit and
// then decays, rendered by per-channel PWM over a shared free-running period counter.
// Optional build macro LED_FADE_GAMMA_EN selects a square-law brightness-to-duty map.
module led_fade_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 50000,
  parameter int DECAY_STEP = 8
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  led_fade_pwm_if.slave bus
);
  localparam int DW = $clog2(DECAY_DIV);
  localparam logic [PWM_BITS-1:0] MAX   = '1;
  localparam logic [PWM_BITS-1:0] LAST  = MAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] STEP  = PWM_BITS'(DECAY_STEP);
  localparam logic [DW-1:0]       DLAST = DW'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       decay_cnt;
  logic [PWM_BITS-1:0] bright [4];
  logic [PWM_BITS-1:0] duty [4];
  logic                decay_tick;
  logic                boundary;
  logic [3:0]          pwm_vec;

  function automatic logic [PWM_BITS-1:0] map_b(input logic [PWM_BITS-1:0] b);
`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b};
    return (b == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
`else
    return b;
`endif
  endfunction

  assign decay_tick = decay_cnt == DLAST;
  assign boundary   = pwm_cnt == LAST;

  // Free-running PWM period counter and independent decay prescaler
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      pwm_cnt   <= '0;
      decay_cnt <= '0;
    end else begin
      pwm_cnt   <= boundary ? '0 : pwm_cnt + PWM_BITS'(1);
      decay_cnt <= decay_tick ? '0 : decay_cnt + DW'(1);
    end

  // Brightness: a lit input beats decay; decay saturates at zero; duty is latched only at the
  // period boundary so a PWM period never changes width mid-way
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        bright[i] <= '0;
        duty[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        bright[i] <= bus.led_in[i] ? MAX :
                     decay_tick ? ((bright[i] >= STEP) ? bright[i] - STEP : '0) : bright[i];
        if (boundary) duty[i] <= map_b(bright[i]);
      end
    end

  // PWM compare: high for the first duty cycles of each period
  always_comb begin
    pwm_vec = '0;
    for (int i = 0; i < 4; i++) pwm_vec[i] = pwm_cnt < duty[i];
  end

  // Registered LED drive: PWM in fade mode, one-cycle-delayed pattern in bypass
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) bus.led_out <= '0;
    else bus.led_out <= bus.fade_en ? pwm_vec : bus.led_in;
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: randomized and directed bench for led_fade_pwm against a time-indexed model.
module tb_led_fade_pwm;
  localparam int MAXV = 15;
  localparam int DIV  = 4;
  localparam int STP  = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  led_fade_pwm_if ifc ();

  led_fade_pwm #(.PWM_BITS(4), .DECAY_DIV(DIV), .DECAY_STEP(STP)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(ifc.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total = 0;
  int n = 0;
  int m_bright [4];
  int m_duty [4];
  logic [3:0] m_led = '0;

  function automatic int gmap(input int b);
`ifdef LED_FADE_GAMMA_EN
    return (b == MAXV) ? MAXV : (b * b) / 16;
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    n = 0;
    m_led = '0;
    for (int i = 0; i < 4; i++) begin
      m_bright[i] = 0;
      m_duty[i] = 0;
    end
  endtask

  // n = edges since reset release, so the period phase is n % MAXV and a decay step
  // happens on every DIV-th edge
  task automatic step(input logic [3:0] li, input logic fe);
    ifc.led_in = li;
    ifc.fade_en = fe;
    for (int i = 0; i < 4; i++) m_led[i] = fe ? ((n % MAXV) < m_duty[i]) : li[i];
    if (n % MAXV == MAXV - 1)
      for (int i = 0; i < 4; i++) m_duty[i] = gmap(m_bright[i]);
    for (int i = 0; i < 4; i++)
      if (li[i]) m_bright[i] = MAXV;
      else if (n % DIV == DIV - 1) m_bright[i] = (m_bright[i] > STP) ? m_bright[i] - STP : 0;
    n++;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic release_reset();
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ifc.led_in = '0;
    ifc.fade_en = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    total++;
    if (ifc.led_out !== 4'b0000) $display("FAIL reset_out: got %b want 0000", ifc.led_out);
    else passed++;
    release_reset();
    for (int k = 0; k < 200; k++) begin
      step(4'b0000, 1'b1);
      total++;
      if (ifc.led_out !== 4'b0000) $display("FAIL idle_out cyc %0d: got %b want 0000", k, ifc.led_out);
      else passed++;
    end
    repeat (3) step(4'b1111, 1'b0);
    total++;
    if (ifc.led_out !== 4'b1111) $display("FAIL pre_reset_out: got %b want 1111", ifc.led_out);
    else passed++;
    #2;
    sys_rst_n = 1'b0;
    #1;
    total++;
    if (ifc.led_out !== 4'b0000) $display("FAIL async_reset_out: got %b want 0000", ifc.led_out);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut.bright[i] !== 4'd0 || dut.duty[i] !== 4'd0)
        $display("FAIL async_reset_ch%0d: got bright %0d duty %0d want 0 0", i, dut.bright[i], dut.duty[i]);
      else passed++;
    end
    total++;
    if (dut.pwm_cnt !== 4'd0 || dut.decay_cnt !== 2'd0)
      $display("FAIL async_reset_cnt: got pwm %0d decay %0d want 0 0", dut.pwm_cnt, dut.decay_cnt);
    else passed++;
    release_reset();
  endtask

  task automatic test_full_on();
    step(4'b0001, 1'b1);
    total++;
    if (dut.bright[0] !== 4'd15) $display("FAIL full_on_bright: got %0d want 15", dut.bright[0]);
    else passed++;
    for (int k = 0; k < 45; k++) begin
      step(4'b0001, 1'b1);
      total++;
      if (ifc.led_out !== m_led) $display("FAIL full_on_out cyc %0d: got %b want %b", k, ifc.led_out, m_led);
      else passed++;
    end
    total++;
    if (ifc.led_out !== 4'b0001) $display("FAIL full_on_steady: got %b want 0001", ifc.led_out);
    else passed++;
  endtask

  task automatic test_decay();
    for (int k = 0; k < 50; k++) begin
      step(4'b0000, 1'b1);
      total++;
      if (ifc.led_out !== m_led || dut.bright[0] !== 4'(m_bright[0]))
        $display("FAIL decay cyc %0d: got out %b bright %0d want out %b bright %0d",
                 k, ifc.led_out, dut.bright[0], m_led, m_bright[0]);
      else passed++;
    end
    total++;
    if (dut.bright[0] !== 4'd0) $display("FAIL decay_saturate: got %0d want 0", dut.bright[0]);
    else passed++;
  endtask

  task automatic test_tick_priority();
    int guard = 0;
    step(4'b0100, 1'b1);
    while (!(m_bright[2] == 7 && n % DIV == DIV - 1) && guard < 60) begin
      step(4'b0000, 1'b1);
      guard++;
    end
    total++;
    if (guard >= 60) $display("FAIL tick_setup: got timeout want bright 7 on tick");
    else if (dut.bright[2] !== 4'd7) $display("FAIL tick_setup: got %0d want 7", dut.bright[2]);
    else passed++;
    step(4'b0100, 1'b1);
    total++;
    if (dut.bright[2] !== 4'd15) $display("FAIL tick_priority: got %0d want 15", dut.bright[2]);
    else passed++;
  endtask

  task automatic test_bypass();
    logic [3:0] pats [4];
    pats[0] = 4'b0001;
    pats[1] = 4'b0010;
    pats[2] = 4'b0100;
    pats[3] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      step(pats[k], 1'b0);
      total++;
      if (ifc.led_out !== pats[k]) $display("FAIL bypass %0d: got %b want %b", k, ifc.led_out, pats[k]);
      else passed++;
    end
    for (int k = 0; k < 30; k++) begin
      step(4'b0000, 1'b1);
      total++;
      if (ifc.led_out !== m_led) $display("FAIL resume_out cyc %0d: got %b want %b", k, ifc.led_out, m_led);
      else passed++;
    end
    total++;
    if (dut.pwm_cnt !== 4'(n % MAXV)) $display("FAIL resume_phase: got %0d want %0d", dut.pwm_cnt, n % MAXV);
    else passed++;
  endtask

  task automatic test_random();
    logic fe = 1'b1;
    logic [3:0] li;
    for (int k = 0; k < 600; k++) begin
      li = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 39) == 0) fe = ~fe;
      step(li, fe);
      total++;
      if (ifc.led_out !== m_led) $display("FAIL random_out cyc %0d: got %b want %b", k, ifc.led_out, m_led);
      else passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dut.bright[i] !== 4'(m_bright[i]))
          $display("FAIL random_bright%0d cyc %0d: got %0d want %0d", i, k, dut.bright[i], m_bright[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_on();
    test_decay();
    test_tick_priority();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
